dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
//  Load/store sequencer between the MEM stage and a synchronous data memory.
//  - Accepts one access at a time over a valid/ready request handshake.
//  - Aligns store data into byte lanes and generates byte write-enables.
//  - Waits out the memory read latency, then byte/half-extends load data.
//  - Returns a held response; misaligned or illegal-width accesses are trapped before reaching memory.
// PARAMETERS
//  RD_LAT  1  cycles from the dm_en cycle to valid dm_rdata; legal range 1..7
//  AW      32 byte-address width
// PORTS
//  clk          in   1   clock; all state changes on posedge
//  rst          in   1   synchronous reset, active-high
//  req_valid    in   1   access request present
//  req_ready    out  1   controller can accept; = (state==IDLE) & ~rst
//  req_we       in   1   1 = store, 0 = load
//  req_ctr      in   3   width/extend code; table under BEHAVIOUR
//  req_addr     in   AW  byte address
//  req_wdata    in   32  store data, right-justified
//  dm_en        out  1   memory access strobe, exactly one cycle per legal access
//  dm_we        out  4   byte write enables; lane i = bits [8i+7:8i]
//  dm_addr      out  AW  word address, {req_addr[AW-1:2],2'b00}
//  dm_wdata     out  32  lane-aligned store data
//  dm_rdata     in   32  memory read data
//  resp_valid   out  1   response held until resp_ready
//  resp_ready   in   1   consumer takes response
//  resp_rdata   out  32  extended load data; 0 for stores and errors
//  resp_err     out  1   misaligned or illegal code; no memory access made
// BEHAVIOUR
//  - Code table, loads and stores:
//      000 word, 001 byte zero-extend, 010 byte sign-extend, 011 half zero-extend, 100 half sign-extend.
//      Stores treat 001/010 as byte and 011/100 as half. Codes 101..111 are illegal.
//  - Alignment: word needs addr[1:0]==0; half needs addr[0]==0; byte is always aligned.
//  - FSM states IDLE, ACC, WAIT, RESP. Reset puts the FSM in IDLE.
//  - Reset values: dm_en=0, dm_we=0, dm_addr=0, dm_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0.
//  - Accept = req_valid & req_ready in cycle T. Address, ctr, we and wdata are registered at T.
//  - Illegal access: IDLE->RESP. resp_valid=1 and resp_err=1 from T+1. No dm_en, no dm_we.
//  - Legal access: IDLE->ACC. In cycle T+1, dm_en=1 with dm_addr and dm_wdata valid.
//      Store: dm_we is decoded from lane and size; dm_wdata replicates the byte/half across lanes.
//      Store: byte at addr 2 gives dm_we=0100; half at addr 2 gives dm_we=1100; word gives 1111.
//      Load: dm_we=0.
//  - Store: ACC->RESP. resp_valid rises at T+2 with resp_err=0 and resp_rdata=0.
//  - Load: ACC->WAIT with a latency counter loaded to RD_LAT-1.
//      WAIT decrements the counter; at counter==0 it samples dm_rdata and goes to RESP.
//      dm_rdata is sampled at cycle T+1+RD_LAT; resp_valid rises at T+2+RD_LAT.
//  - Load extension: the lane is selected by the registered addr[1:0] (byte) or addr[1] (half).
//    Zero- or sign-extend per code.
//  - RESP holds resp_* stable while resp_ready=0. When resp_ready=1: RESP->IDLE and resp_valid=0 next cycle.
//  - Back-to-back: req_ready is 0 in ACC/WAIT/RESP, so the next accept is at the earliest the cycle after RESP exits.
//  - dm_en/dm_we are one-cycle pulses; they return to 0 in every state other than ACC.
//  - Reset mid-operation: next edge -> IDLE with all outputs at reset values.
//    The in-flight access is dropped, no response is produced, and a write already pulsed is not undone.
//  - Counter width is 3 bits. RD_LAT outside 1..7 is a configuration error, trapped by an elaboration check.
// STRUCTURE
//  - Shared package lxb_mem_pkg holds:
//      code localparams LD_W=3'b000, LD_BU=3'b001, LD_B=3'b010, LD_HU=3'b011, LD_H=3'b100;
//      a size-decode function (ctr -> 0 byte/1 half/2 word/3 illegal);
//      FSM state encodings.
//  - One sub-module st_align (comb): in addr[1:0], size, wdata; out we[3:0], lane-aligned wdata.
//    It is reused by the future cache-fill path.
//  - Load extension stays inline in this block.
// TESTING
//  - Reset, then idle with rst=0: req_ready=1, dm_en=0, resp_valid=0; hold rst=1 while req_valid=1 -> nothing accepted.
//  - Load, RD_LAT=1: LB at addr 0x13 (lane 3), mem word 0x80FF_1234 -> dm_en at T+1 with dm_addr=0x10.
//    resp_valid at T+3 with resp_rdata=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
//  - Store SH at 0x22, wdata=0x0000_BEEF -> at T+1 dm_we=1100 and dm_wdata[31:16]=0xBEEF.
//    resp_valid at T+2 with resp_err=0.
//  - LW at 0x06 and SH at 0x01 -> resp_err=1 at T+1 with dm_en never asserted; ctr=3'b110 -> resp_err=1.
//  - RD_LAT=3 with resp_ready held low 5 cycles: resp_valid rises at T+5, resp_rdata stays stable,
//    req_ready stays 0; resp_ready=1 -> IDLE the next cycle.
//  - rst asserted in WAIT (RD_LAT=3): no resp_valid ever for that load; the next request is accepted normally.

Source files
------------

// File: rtl/lxb_mem_pkg.sv
// Shared definitions for the load/store path: width/extend codes,
// the code-to-size decode and the access sequencer state encoding.
package lxb_mem_pkg;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_BU = 3'b001;
  localparam logic [2:0] LD_B  = 3'b010;
  localparam logic [2:0] LD_HU = 3'b011;
  localparam logic [2:0] LD_H  = 3'b100;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dm_state_e;

  // Stores reuse the load codes: both byte codes mean byte, both half codes mean half.
  function automatic logic [1:0] size_decode(input logic [2:0] ctr);
    logic [1:0] sz;
    case (ctr)
      LD_W:        sz = SZ_WORD;
      LD_BU, LD_B: sz = SZ_BYTE;
      LD_HU, LD_H: sz = SZ_HALF;
      default:     sz = SZ_ILL;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/st_align.sv
// Store lane alignment: byte write-enables plus store data replicated
// across lanes so the enabled lanes always carry the right bytes.
module st_align
  import lxb_mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [3:0]  we,
  output logic [31:0] wdata_al
);

  always_comb begin
    we       = 4'b0000;
    wdata_al = wdata;
    case (size)
      SZ_BYTE: begin
        we       = 4'b0001 << addr;
        wdata_al = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        we       = addr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        we       = 4'b1111;
        wdata_al = wdata;
      end
      default: begin
        we       = 4'b0000;
        wdata_al = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the MEM stage and a synchronous data memory:
// one access at a time, store alignment, read-latency wait, load extension.
module dm_access_ctrl
  import lxb_mem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_ctr,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          dm_en,
  output logic [3:0]    dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err
);

  // The latency counter is 3 bits wide, so only 1..7 cycles can be waited out.
  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("dm_access_ctrl: RD_LAT must be in 1..7");
  end

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  dm_state_e     state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [2:0]    ctr_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [2:0]    cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [1:0]    size_in;
  logic [1:0]    size_q;
  logic          aligned_in;
  logic          legal_in;
  logic          accept;
  logic [3:0]    st_we;
  logic [31:0]   st_wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign size_in = size_decode(req_ctr);
  assign size_q  = size_decode(ctr_q);

  always_comb begin
    aligned_in = 1'b0;
    case (size_in)
      SZ_BYTE: aligned_in = 1'b1;
      SZ_HALF: aligned_in = ~req_addr[0];
      SZ_WORD: aligned_in = (req_addr[1:0] == 2'b00);
      default: aligned_in = 1'b0;
    endcase
  end

  assign legal_in = aligned_in & (size_in != SZ_ILL);
  assign accept   = req_valid & req_ready;

  st_align u_st_align (
    .addr     (addr_q[1:0]),
    .size     (size_q),
    .wdata    (wdata_q),
    .we       (st_we),
    .wdata_al (st_wdata)
  );

  // Load lane select uses the registered address; extension follows the code.
  always_comb begin
    ld_byte = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (ctr_q)
      LD_BU:   ld_ext = {24'b0, ld_byte};
      LD_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LD_HU:   ld_ext = {16'b0, ld_half};
      LD_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      default: ld_ext = dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    dm_en      = 1'b0;
    dm_we      = 4'b0000;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (accept) begin
          state_nxt = legal_in ? ACC : RESP;
        end
      end
      ACC: begin
        dm_en     = 1'b1;
        dm_we     = we_q ? st_we : 4'b0000;
        state_nxt = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response data is cleared on accept so stores and trapped accesses return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      ctr_q   <= 3'b000;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        ctr_q   <= req_ctr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        err_q   <= ~legal_in;
        rdata_q <= 32'h0;
      end
      if (state == ACC) begin
        cnt_q <= CNT_INIT;
      end
      if (state == WAIT) begin
        if (cnt_q != 3'd0) begin
          cnt_q <= cnt_q - 3'd1;
        end else begin
          rdata_q <= ld_ext;
        end
      end
    end
  end

  assign dm_addr    = {addr_q[AW-1:2], 2'b00};
  assign dm_wdata   = st_wdata;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each with
// its own latency-accurate memory, checked against a transaction-level model.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [2:0]  req_ctr    [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_ready [2];
  logic [31:0] dm_rdata   [2];
  logic        req_ready  [2];
  logic        dm_en      [2];
  logic [3:0]  dm_we      [2];
  logic [31:0] dm_addr    [2];
  logic [31:0] dm_wdata   [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [31:0] ref_mem [2][64];
  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h80FF_1234 : ((32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234);
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Access size in bytes; 0 marks an illegal code.
  function automatic int size_of(input logic [2:0] ctr);
    case (ctr)
      3'd0:       return 4;
      3'd1, 3'd2: return 1;
      3'd3, 3'd4: return 2;
      default:    return 0;
    endcase
  endfunction

  // Environment memory: reloaded during reset, read data appears RD_LAT cycles
  // after the dm_en cycle and is noise at every other time.
  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] mem  [64];
    logic [31:0] pipe [3];

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (dm_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (dm_we[g][b]) mem[dm_addr[g][7:2]][8*b +: 8] <= dm_wdata[g][8*b +: 8];
      end
      pipe[0] <= dm_en[g] ? mem[dm_addr[g][7:2]] : $urandom;
      for (int k = 1; k < 3; k++) pipe[k] <= pipe[k-1];
    end

    assign dm_rdata[g] = pipe[L-1];

    dm_access_ctrl #(.RD_LAT(L), .AW(32)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_ctr    (req_ctr[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .dm_en      (dm_en[g]),
      .dm_we      (dm_we[g]),
      .dm_addr    (dm_addr[g]),
      .dm_wdata   (dm_wdata[g]),
      .dm_rdata   (dm_rdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  task automatic reinit_ref();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 64; i++) ref_mem[u][i] = init_word(i);
  endtask

  // One complete access on instance u, starting and ending at a negedge.
  task automatic do_access(input int u, input logic we, input logic [2:0] ctr,
                           input logic [7:0] a8, input logic [31:0] wd,
                           input int hold, output logic [31:0] got);
    int          sz;
    int          lane;
    int          exp_lat;
    int          cyc;
    logic        legal;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic [31:0] word;
    logic [31:0] sh;
    logic [31:0] addr;
    addr   = {24'h0, a8};
    sz     = size_of(ctr);
    lane   = int'(a8[1:0]);
    legal  = (sz == 0) ? 1'b0 : ((lane % sz) == 0);
    exp_we = we ? 4'(((1 << sz) - 1) << lane) : 4'b0000;
    exp_wd = (sz == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
             (sz == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
    word   = ref_mem[u][a8[7:2]];
    sh     = word >> (8 * lane);
    exp_rd = 32'h0;
    if (legal && !we) begin
      case (ctr)
        3'd1:    exp_rd = sh & 32'hFF;
        3'd2:    exp_rd = ((sh & 32'hFF) >= 32'h80) ? ((sh & 32'hFF) + 32'hFFFF_FF00) : (sh & 32'hFF);
        3'd3:    exp_rd = sh & 32'hFFFF;
        3'd4:    exp_rd = ((sh & 32'hFFFF) >= 32'h8000) ? ((sh & 32'hFFFF) + 32'hFFFF_0000) : (sh & 32'hFFFF);
        default: exp_rd = word;
      endcase
    end
    if (legal && we)
      for (int b = 0; b < 4; b++)
        if (exp_we[b]) ref_mem[u][a8[7:2]][8*b +: 8] = exp_wd[8*b +: 8];
    exp_lat = !legal ? 1 : (we ? 2 : 2 + lat_of(u));

    n_checks++;
    if (req_ready[u] !== 1'b1) begin n_fail++; $display("[TB] FAIL u%0d req_ready before request: got %b want 1", u, req_ready[u]); end
    req_valid[u] = 1'b1; req_we[u] = we; req_ctr[u] = ctr; req_addr[u] = addr; req_wdata[u] = wd;
    @(negedge clk);
    req_valid[u] = 1'b0;
    cyc = 1;
    n_checks++;
    if (dm_en[u] !== legal) begin n_fail++; $display("[TB] FAIL u%0d dm_en at T+1 (ctr=%0d addr=%h): got %b want %b", u, ctr, addr, dm_en[u], legal); end
    if (legal) begin
      n_checks++;
      if (dm_addr[u] !== (addr & ~32'h3)) begin n_fail++; $display("[TB] FAIL u%0d dm_addr: got %h want %h", u, dm_addr[u], addr & ~32'h3); end
      n_checks++;
      if (dm_we[u] !== exp_we) begin n_fail++; $display("[TB] FAIL u%0d dm_we (addr=%h): got %b want %b", u, addr, dm_we[u], exp_we); end
      if (we) begin
        n_checks++;
        if (dm_wdata[u] !== exp_wd) begin n_fail++; $display("[TB] FAIL u%0d dm_wdata: got %h want %h", u, dm_wdata[u], exp_wd); end
      end
    end
    while (resp_valid[u] !== 1'b1 && cyc < 20) begin
      n_checks++;
      if (req_ready[u] !== 1'b0) begin n_fail++; $display("[TB] FAIL u%0d req_ready while busy: got %b want 0", u, req_ready[u]); end
      @(negedge clk);
      cyc++;
      n_checks++;
      if (dm_en[u] !== 1'b0) begin n_fail++; $display("[TB] FAIL u%0d dm_en after access cycle: got %b want 0", u, dm_en[u]); end
    end
    n_checks++;
    if (cyc != exp_lat) begin n_fail++; $display("[TB] FAIL u%0d response latency: got %0d want %0d", u, cyc, exp_lat); end
    n_checks++;
    if (resp_err[u] !== !legal) begin n_fail++; $display("[TB] FAIL u%0d resp_err: got %b want %b", u, resp_err[u], !legal); end
    n_checks++;
    if (resp_rdata[u] !== exp_rd) begin n_fail++; $display("[TB] FAIL u%0d resp_rdata (ctr=%0d addr=%h): got %h want %h", u, ctr, addr, resp_rdata[u], exp_rd); end
    got = resp_rdata[u];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid[u] !== 1'b1 || resp_rdata[u] !== exp_rd || req_ready[u] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL u%0d response hold: got valid=%b rdata=%h ready=%b want valid=1 rdata=%h ready=0",
                 u, resp_valid[u], resp_rdata[u], req_ready[u], exp_rd);
      end
    end
    resp_ready[u] = 1'b1;
    @(negedge clk);
    resp_ready[u] = 1'b0;
    n_checks++;
    if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL u%0d after resp_ready: got valid=%b ready=%b want valid=0 ready=1", u, resp_valid[u], req_ready[u]);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b1; req_we[u] = 1'b1; req_ctr[u] = 3'd0;
      req_addr[u] = 32'h40; req_wdata[u] = 32'hDEAD_BEEF; resp_ready[u] = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (req_ready[u] !== 1'b0 || dm_en[u] !== 1'b0 || resp_valid[u] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL u%0d during reset: got ready=%b dm_en=%b resp_valid=%b want all 0", u, req_ready[u], dm_en[u], resp_valid[u]);
        end
      end
    end
    for (int u = 0; u < 2; u++) req_valid[u] = 1'b0;
    rst = 1'b0;
    reinit_ref();
    repeat (2) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (req_ready[u] !== 1'b1 || dm_en[u] !== 1'b0 || resp_valid[u] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL u%0d idle after reset: got ready=%b dm_en=%b resp_valid=%b want 1/0/0", u, req_ready[u], dm_en[u], resp_valid[u]);
        end
        n_checks++;
        if (dm_we[u] !== 4'b0 || dm_addr[u] !== 32'h0 || dm_wdata[u] !== 32'h0 || resp_rdata[u] !== 32'h0 || resp_err[u] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL u%0d reset values: got we=%b addr=%h wdata=%h rdata=%h err=%b want all 0",
                   u, dm_we[u], dm_addr[u], dm_wdata[u], resp_rdata[u], resp_err[u]);
        end
      end
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] got;
    $display("[TB] test_load_extend");
    do_access(0, 1'b0, 3'd2, 8'h13, 32'h0, 0, got);
    n_checks++;
    if (got !== 32'hFFFF_FF80) begin n_fail++; $display("[TB] FAIL LB 0x13: got %h want ffffff80", got); end
    do_access(0, 1'b0, 3'd1, 8'h13, 32'h0, 0, got);
    n_checks++;
    if (got !== 32'h0000_0080) begin n_fail++; $display("[TB] FAIL LBU 0x13: got %h want 00000080", got); end
    do_access(0, 1'b0, 3'd4, 8'h12, 32'h0, 0, got);
    n_checks++;
    if (got !== 32'hFFFF_80FF) begin n_fail++; $display("[TB] FAIL LH 0x12: got %h want ffff80ff", got); end
  endtask

  task automatic test_store_half();
    logic [31:0] got;
    $display("[TB] test_store_half");
    do_access(0, 1'b1, 3'd3, 8'h22, 32'h0000_BEEF, 0, got);
    do_access(0, 1'b0, 3'd3, 8'h22, 32'h0, 0, got);
    n_checks++;
    if (got !== 32'h0000_BEEF) begin n_fail++; $display("[TB] FAIL readback SH 0x22: got %h want 0000beef", got); end
    do_access(0, 1'b1, 3'd1, 8'h21, 32'h0000_00A5, 0, got);
    do_access(0, 1'b0, 3'd0, 8'h20, 32'h0, 0, got);
  endtask

  task automatic test_errors();
    logic [31:0] got;
    $display("[TB] test_errors");
    do_access(0, 1'b0, 3'd0, 8'h06, 32'h0, 0, got);
    do_access(0, 1'b1, 3'd4, 8'h01, 32'h1234_5678, 0, got);
    do_access(1, 1'b0, 3'd6, 8'h00, 32'h0, 1, got);
    do_access(1, 1'b1, 3'd7, 8'h08, 32'hFFFF_FFFF, 0, got);
  endtask

  task automatic test_latency_hold();
    logic [31:0] got;
    $display("[TB] test_latency_hold");
    do_access(1, 1'b0, 3'd0, 8'h40, 32'h0, 5, got);
    do_access(1, 1'b1, 3'd0, 8'h40, 32'hCAFE_F00D, 2, got);
    do_access(1, 1'b0, 3'd0, 8'h40, 32'h0, 0, got);
    n_checks++;
    if (got !== 32'hCAFE_F00D) begin n_fail++; $display("[TB] FAIL LW after SW 0x40: got %h want cafef00d", got); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    $display("[TB] test_reset_mid");
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_ctr[1] = 3'd0; req_addr[1] = 32'h44; req_wdata[1] = 32'h0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_valid[1] !== 1'b0 || dm_en[1] !== 1'b0 || dm_addr[1] !== 32'h0 || resp_rdata[1] !== 32'h0 || req_ready[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset in WAIT: got valid=%b dm_en=%b addr=%h rdata=%h ready=%b want all 0",
               resp_valid[1], dm_en[1], dm_addr[1], resp_rdata[1], req_ready[1]);
    end
    rst = 1'b0;
    reinit_ref();
    repeat (8) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL dropped load: got valid=%b ready=%b want valid=0 ready=1", resp_valid[1], req_ready[1]);
      end
    end
    do_access(1, 1'b0, 3'd4, 8'h46, 32'h0, 1, got);
  endtask

  task automatic test_random();
    logic [31:0] got;
    int          u;
    int          r;
    logic [2:0]  ctr;
    $display("[TB] test_random");
    for (int i = 0; i < 60; i++) begin
      u   = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      ctr = (r < 8) ? 3'(r % 5) : 3'($urandom_range(5, 7));
      do_access(u, 1'($urandom), ctr, 8'($urandom), $urandom, int'($urandom_range(0, 2)), got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_we[u] = 1'b0; req_ctr[u] = 3'd0;
      req_addr[u] = 32'h0; req_wdata[u] = 32'h0; resp_ready[u] = 1'b0;
    end
    test_reset();
    test_load_extend();
    test_store_half();
    test_errors();
    test_latency_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
